// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencing FSM driving cs/count/ld_sel with a valid/ack result hold
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int CW = 8
) (
`ifdef AES_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          out_ack,
  output logic [2:0]    cs,
  output logic [CW-1:0] count,
  output logic          ld_sel,
  output logic          ready,
  output logic          busy,
  output logic          out_valid
);

  localparam logic [2:0] CS_RES = 3'b000;
  localparam logic [2:0] CS_ADD = 3'b010;
  localparam logic [2:0] CS_SUB = 3'b011;
  localparam logic [2:0] CS_SHI = 3'b100;
  localparam logic [2:0] CS_MIX = 3'b101;
  localparam logic [2:0] CS_FIN = 3'b111;

  localparam logic [CW-1:0] NR_C  = CW'(NR);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ARK0,
    S_SUB,
    S_SHI,
    S_MIX,
    S_ARK,
    S_FINAL,
    S_DONE
  } state_t;

  state_t state;
  logic   abort_req;
  logic   in_flight;

`ifdef AES_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_flight = (state != S_IDLE) && (state != S_DONE);

  // Outputs are loaded together with the state they belong to, so they are
  // stable a half cycle before the datapath samples on the falling edge.
  always_ff @(posedge clk) begin
    if (rst || (abort_req && in_flight)) begin
      state     <= S_IDLE;
      cs        <= CS_FIN;
      count     <= '0;
      ld_sel    <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            cs     <= CS_RES;
            count  <= '0;
            ld_sel <= 1'b1;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          state  <= S_ARK0;
          cs     <= CS_ADD;
          ld_sel <= 1'b0;
        end
        S_ARK0: begin
          state <= S_SUB;
          cs    <= CS_SUB;
          count <= ONE_C;
        end
        S_SUB: begin
          state <= S_SHI;
          cs    <= CS_SHI;
        end
        S_SHI: begin
          // The last round skips MixColumns.
          if (count < NR_C) begin
            state <= S_MIX;
            cs    <= CS_MIX;
          end else begin
            state <= S_ARK;
            cs    <= CS_ADD;
          end
        end
        S_MIX: begin
          state <= S_ARK;
          cs    <= CS_ADD;
        end
        S_ARK: begin
          if (count < NR_C) begin
            state <= S_SUB;
            cs    <= CS_SUB;
            count <= count + ONE_C;
          end else begin
            state <= S_FINAL;
            cs    <= CS_FIN;
          end
        end
        S_FINAL: begin
          state     <= S_DONE;
          cs        <= CS_FIN;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ack) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            ready     <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cs        <= CS_FIN;
          count     <= '0;
          ld_sel    <= 1'b0;
          ready     <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
